// File: rtl/i2c_slave_responder.sv
// I2C slave: SCL/SDA go through a 2-FF synchronizer and a glitch filter, then into
// a 7-bit address match. The slave receives write bytes, returns read bytes and
// controls SDA open-drain.
//
// state     | meaning
// IDLE      | bus free (or after reset), waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving ACK for a matched address
// RX_BYTE   | shifting in a write data byte
// RX_ACK    | driving ACK for a received byte
// TX_BYTE   | driving read data MSB-first
// TX_ACK    | sampling master ACK/NACK on the 9th clock
// WAIT_STOP | not addressed or NACKed; bus ignored until START/STOP
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3A,
    parameter int         FILT_LEN   = 3
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    logic [1:0]          scl_s_q, sda_s_q;
    logic [FILT_LEN-1:0] scl_h_q, sda_h_q;
    logic                scl_f_q, sda_f_q, scl_p_q, sda_p_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic       sda_oe_q, sda_oe_d, rw_q, rw_d, busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d, addr_hit_q, addr_hit_d;
    logic       start_det_q, start_det_d, stop_det_q, stop_det_d;
    logic       load_tx;
    logic [7:0] shift_in, tx_byte;

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_f_q & ~scl_p_q;
    assign scl_fall = ~scl_f_q & scl_p_q;
    assign start_c  = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop_c   = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign shift_in = {shift_q[6:0], sda_f_q};
    assign tx_byte  = tx_valid ? tx_data : 8'hFF;

    always_ff @(posedge pclk) begin
        if (preset) begin
            scl_s_q     <= '1;
            sda_s_q     <= '1;
            scl_h_q     <= '1;
            sda_h_q     <= '1;
            scl_f_q     <= 1'b1;
            sda_f_q     <= 1'b1;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            sda_oe_q    <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            scl_s_q <= {scl_s_q[0], scl_i};
            sda_s_q <= {sda_s_q[0], sda_i};
            scl_h_q <= (scl_h_q << 1) | FILT_LEN'(scl_s_q[1]);
            sda_h_q <= (sda_h_q << 1) | FILT_LEN'(sda_s_q[1]);
            // A level is accepted only once the whole history window agrees.
            if (&scl_h_q)       scl_f_q <= 1'b1;
            else if (~|scl_h_q) scl_f_q <= 1'b0;
            if (&sda_h_q)       sda_f_q <= 1'b1;
            else if (~|sda_h_q) sda_f_q <= 1'b0;
            scl_p_q     <= scl_f_q;
            sda_p_q     <= sda_f_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            sda_oe_q    <= sda_oe_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            addr_hit_q  <= addr_hit_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        sda_oe_d    = sda_oe_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        addr_hit_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        load_tx     = 1'b0;

        if (start_c) begin
            state_d     = ADDR;
            cnt_d       = '0;
            shift_d     = '0;
            sda_oe_d    = 1'b0;
            start_det_d = 1'b1;
            busy_d      = 1'b1;
        end else if (stop_c) begin
            state_d    = IDLE;
            cnt_d      = '0;
            sda_oe_d   = 1'b0;
            stop_det_d = 1'b1;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                ADDR, RX_BYTE: if (scl_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (state_q == RX_BYTE) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                        end else if (shift_in[7:1] == SLAVE_ADDR) begin
                            addr_hit_d = 1'b1;
                            rw_d       = shift_in[0];
                            state_d    = ADDR_ACK;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                // First falling edge starts the ACK, the second one ends it.
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else if (state_q == ADDR_ACK && rw_q) begin
                        load_tx = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RX_BYTE;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                        state_d  = TX_ACK;
                    end else begin
                        sda_oe_d   = ~tx_shift_q[6];
                        tx_shift_d = {tx_shift_q[6:0], 1'b1};
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_f_q) state_d = WAIT_STOP;
                        else         cnt_d   = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        load_tx = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (load_tx) begin
            tx_shift_d = tx_byte;
            sda_oe_d   = ~tx_byte[7];
            cnt_d      = '0;
            state_d    = TX_BYTE;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign tx_ready  = load_tx & ~preset;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign addr_hit  = addr_hit_q;
    assign rw        = rw_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master on a wired-AND SDA,
// a transaction table plus hand-written repeated-START, reset and glitch sequences.
module tb_i2c_slave_responder;
    localparam int Q = 12;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       sda_oe, tx_ready, rx_valid, addr_hit, rw, start_det, stop_det, busy;
    logic [7:0] rx_data;
    logic       sda_bus;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 pclk = ~pclk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h3A), .FILT_LEN(3)) dut (
        .pclk(pclk), .preset(preset), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .addr_hit(addr_hit), .rw(rw),
        .start_det(start_det), .stop_det(stop_det), .busy(busy)
    );

    int         n_hit = 0, n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0;
    logic       rw_cap = 1'b0;
    logic [7:0] rx_cap = 8'h00;

    always @(posedge pclk) begin
        if (addr_hit)  begin n_hit <= n_hit + 1; rw_cap <= rw; end
        if (rx_valid)  begin n_rxv <= n_rxv + 1; rx_cap <= rx_data; end
        if (tx_ready)  n_txr   <= n_txr + 1;
        if (start_det) n_start <= n_start + 1;
        if (stop_det)  n_stop  <= n_stop + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, output logic s);
        tick(Q); sda_m = b;
        tick(Q); scl_m = 1'b1;
        tick(Q); s = sda_bus;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(mack, s);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdat;
        logic [7:0] txd;
        logic       tv;
        logic       exp_ack;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       ack;
        logic [7:0] b;
        int h0, r0, t0, s0, p0;

        vecs[0] = '{8'h74, 8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{8'h74, 8'h5A, 8'h00, 1'b0, 1'b1, 8'h5A};
        vecs[2] = '{8'h75, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h3C};
        vecs[3] = '{8'h75, 8'h00, 8'h12, 1'b0, 1'b1, 8'hFF};
        vecs[4] = '{8'h50, 8'h33, 8'h00, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{8'h77, 8'h00, 8'h81, 1'b1, 1'b0, 8'h00};

        tick(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        check("rst_start_stop", 32'({start_det, stop_det}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rw", 32'(rw), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        preset = 1'b0;
        tick(4);

        for (int v = 0; v < 6; v++) begin
            tx_data  = vecs[v].txd;
            tx_valid = vecs[v].tv;
            h0 = n_hit; r0 = n_rxv; t0 = n_txr; s0 = n_start; p0 = n_stop;
            i2c_start();
            send_byte(vecs[v].addr, ack);
            check($sformatf("v%0d_addr_ack_line", v), 32'(ack), 32'(!vecs[v].exp_ack));
            tick(Q);
            check($sformatf("v%0d_addr_hit_cnt", v), 32'(n_hit - h0), 32'(vecs[v].exp_ack));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
            if (vecs[v].exp_ack) begin
                check($sformatf("v%0d_rw", v), 32'(rw_cap), 32'(vecs[v].addr[0]));
                if (!vecs[v].addr[0]) begin
                    send_byte(vecs[v].wdat, ack);
                    check($sformatf("v%0d_data_ack_line", v), 32'(ack), 32'd0);
                    tick(Q);
                    check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vecs[v].exp_byte));
                    check($sformatf("v%0d_rx_cap", v), 32'(rx_cap), 32'(vecs[v].exp_byte));
                    check($sformatf("v%0d_rx_valid_cnt", v), 32'(n_rxv - r0), 32'd1);
                end else begin
                    read_byte(1'b1, b);
                    check($sformatf("v%0d_read_byte", v), 32'(b), 32'(vecs[v].exp_byte));
                    tick(Q);
                    check($sformatf("v%0d_tx_ready_cnt", v), 32'(n_txr - t0), 32'd1);
                    check($sformatf("v%0d_sda_oe_nack", v), 32'(sda_oe), 32'd0);
                    check($sformatf("v%0d_state_wait_stop", v), 32'(dut.state_q), 32'd7);
                end
            end else begin
                check($sformatf("v%0d_state_wait_stop", v), 32'(dut.state_q), 32'd7);
                check($sformatf("v%0d_sda_oe_unaddr", v), 32'(sda_oe), 32'd0);
            end
            i2c_stop();
            tick(Q);
            check($sformatf("v%0d_start_cnt", v), 32'(n_start - s0), 32'd1);
            check($sformatf("v%0d_stop_cnt", v), 32'(n_stop - p0), 32'd1);
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
        end

        // Repeated START in the middle of a write data byte.
        tx_data = 8'h96; tx_valid = 1'b1;
        h0 = n_hit; r0 = n_rxv; s0 = n_start;
        i2c_start();
        send_byte(8'h74, ack);
        check("rs_addr1_ack", 32'(ack), 32'd0);
        send_bit(1'b1, ack); send_bit(1'b0, ack); send_bit(1'b1, ack); send_bit(1'b1, ack);
        i2c_start();
        send_byte(8'h75, ack);
        check("rs_addr2_ack", 32'(ack), 32'd0);
        tick(Q);
        check("rs_start_cnt", 32'(n_start - s0), 32'd2);
        check("rs_rx_valid_cnt", 32'(n_rxv - r0), 32'd0);
        check("rs_hit_cnt", 32'(n_hit - h0), 32'd2);
        check("rs_rw", 32'(rw), 32'd1);
        read_byte(1'b1, b);
        check("rs_read_byte", 32'(b), 32'h96);
        i2c_stop();
        tick(Q);

        // Reset while the slave is driving a data-0 bit.
        tx_data = 8'h00; tx_valid = 1'b1;
        i2c_start();
        send_byte(8'h75, ack);
        tick(Q);
        check("mr_sda_oe_before", 32'(sda_oe), 32'd1);
        preset = 1'b1;
        tick(1);
        check("mr_sda_oe_after", 32'(sda_oe), 32'd0);
        check("mr_state_idle", 32'(dut.state_q), 32'd0);
        preset = 1'b0;
        h0 = n_hit; t0 = n_txr; s0 = n_start;
        read_byte(1'b1, b);
        check("mr_bus_released", 32'(b), 32'hFF);
        i2c_stop();
        tick(Q);
        check("mr_hit_cnt", 32'(n_hit - h0), 32'd0);
        check("mr_tx_ready_cnt", 32'(n_txr - t0), 32'd0);
        check("mr_start_cnt", 32'(n_start - s0), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);

        // SDA glitches of 1 and 2 cycles while SCL idles high.
        s0 = n_start; p0 = n_stop;
        sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(20);
        sda_m = 1'b0; tick(2); sda_m = 1'b1; tick(20);
        check("gl_start_cnt", 32'(n_start - s0), 32'd0);
        check("gl_stop_cnt", 32'(n_stop - p0), 32'd0);
        check("gl_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
